// File: rtl/fast_pkg.sv
// Shared definitions for the FAST corner datapath: default geometry and sequencer state encoding.
package fast_pkg;

    localparam int unsigned FAST_DEPTH   = 16;
    localparam int unsigned FAST_ARC_LEN = 9;
    localparam int unsigned FAST_ADDR_W  = $clog2(FAST_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/arc_run_tracker.sv
// Tracks contiguous hit runs around the circle (current, leading, longest) and
// forms the wrap-joined result from the post-update values of the current step.
module arc_run_tracker
    import fast_pkg::*;
#(
    parameter int unsigned DEPTH      = FAST_DEPTH,
    parameter int unsigned ARC_LEN    = FAST_ARC_LEN,
    parameter bit          EARLY_EXIT = 1'b0,
    parameter int unsigned CNT_W      = $clog2(FAST_DEPTH) + 1
) (
    input  logic             clock,
    input  logic             nReset,
    input  logic             clr,
    input  logic             en,
    input  logic             hit,
    input  logic             last,
    output logic [CNT_W-1:0] runLen_next,
    output logic             corner_next,
    output logic             early_next
);

    localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ARC_V   = CNT_W'(ARC_LEN);
    localparam logic [CNT_W-1:0] ONE_V   = CNT_W'(1);

    logic [CNT_W-1:0] curRun;
    logic [CNT_W-1:0] firstRun;
    logic [CNT_W-1:0] maxRun;
    logic             firstOpen;

    logic [CNT_W-1:0] curNext;
    logic [CNT_W-1:0] firstNext;
    logic [CNT_W-1:0] maxNext;
    logic             openNext;
    logic [CNT_W-1:0] wrapSum;
    logic [CNT_W-1:0] finalLen;

    // Post-update run values; counters saturate at DEPTH
    always_comb begin
        curNext   = '0;
        firstNext = firstRun;
        maxNext   = maxRun;
        openNext  = 1'b0;
        if (hit) begin
            curNext   = (curRun >= DEPTH_V) ? curRun : curRun + ONE_V;
            if (firstOpen) begin
                firstNext = (firstRun >= DEPTH_V) ? firstRun : firstRun + ONE_V;
            end
            maxNext   = (curNext > maxRun) ? curNext : maxRun;
            openNext  = firstOpen;
        end
        // Once a miss has been seen the tail and leading runs are disjoint, so the sum stays below DEPTH
        wrapSum     = curNext + firstNext;
        finalLen    = openNext ? DEPTH_V : ((wrapSum > maxNext) ? wrapSum : maxNext);
        early_next  = EARLY_EXIT && (maxNext >= ARC_V);
        runLen_next = (early_next || !last) ? maxNext : finalLen;
        corner_next = (runLen_next >= ARC_V);
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            curRun    <= '0;
            firstRun  <= '0;
            maxRun    <= '0;
            firstOpen <= 1'b0;
        end else if (clr) begin
            curRun    <= '0;
            firstRun  <= '0;
            maxRun    <= '0;
            firstOpen <= 1'b1;
        end else if (en) begin
            curRun    <= curNext;
            firstRun  <= firstNext;
            maxRun    <= maxNext;
            firstOpen <= openNext;
        end
    end

endmodule

// File: rtl/arc_match_sequencer.sv
// Circle-position sequencer: walks DEPTH positions of one candidate pixel and
// reports whether a contiguous (wrapping) hit arc reaches ARC_LEN.
module arc_match_sequencer
    import fast_pkg::*;
#(
    parameter int unsigned DEPTH      = FAST_DEPTH,
    parameter int unsigned ADDR_W     = $clog2(DEPTH),
    parameter int unsigned ARC_LEN    = FAST_ARC_LEN,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic              start,
    input  logic              step,
    input  logic              hit,
    input  logic              abort,
    output logic [ADDR_W-1:0] posAddr,
    output logic              busy,
    output logic              done,
    output logic              isCorner,
    output logic [ADDR_W:0]   runLen
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t            state;
    state_t            stateNext;
    logic [ADDR_W-1:0] posAddrNext;
    logic              busyNext;
    logic              doneNext;
    logic              isCornerNext;
    logic [CNT_W-1:0]  runLenNext;

    logic              last;
    logic              trkClr;
    logic              trkEn;
    logic [CNT_W-1:0]  trkRunLen;
    logic              trkCorner;
    logic              trkEarly;

    assign last = (posAddr == ADDR_W'(DEPTH - 1));

    arc_run_tracker #(
        .DEPTH      (DEPTH),
        .ARC_LEN    (ARC_LEN),
        .EARLY_EXIT (EARLY_EXIT),
        .CNT_W      (CNT_W)
    ) u_tracker (
        .clock       (clock),
        .nReset      (nReset),
        .clr         (trkClr),
        .en          (trkEn),
        .hit         (hit),
        .last        (last),
        .runLen_next (trkRunLen),
        .corner_next (trkCorner),
        .early_next  (trkEarly)
    );

    // Next-state and registered-output values; abort has priority over step
    always_comb begin
        stateNext    = state;
        posAddrNext  = posAddr;
        isCornerNext = isCorner;
        runLenNext   = runLen;
        trkClr       = 1'b0;
        trkEn        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    stateNext    = SCAN;
                    posAddrNext  = '0;
                    isCornerNext = 1'b0;
                    runLenNext   = '0;
                    trkClr       = 1'b1;
                end
            end
            SCAN: begin
                if (abort) begin
                    stateNext   = IDLE;
                    posAddrNext = '0;
                end else if (step) begin
                    trkEn = 1'b1;
                    if (last || trkEarly) begin
                        stateNext    = DONE;
                        posAddrNext  = '0;
                        isCornerNext = trkCorner;
                        runLenNext   = trkRunLen;
                    end else begin
                        posAddrNext = posAddr + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        busyNext = (stateNext != IDLE);
        doneNext = (stateNext == DONE);
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            posAddr  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            isCorner <= 1'b0;
            runLen   <= '0;
        end else begin
            state    <= stateNext;
            posAddr  <= posAddrNext;
            busy     <= busyNext;
            done     <= doneNext;
            isCorner <= isCornerNext;
            runLen   <= runLenNext;
        end
    end

endmodule

// File: tb/tb_arc_match_sequencer.sv
// Randomised self-checking bench for arc_match_sequencer (normal and early-exit builds)
// against a circular-run reference model.
module tb_arc_match_sequencer;

    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int ARC_LEN = 9;

    logic clock;
    logic nReset;
    logic start, step, hit, abort;
    logic sel;

    logic startD, stepD, hitD, abortD;
    logic startE, stepE, hitE, abortE;
    logic [ADDR_W-1:0] posAddrD, posAddrE, posAddrS;
    logic busyD, busyE, busyS;
    logic doneD, doneE, doneS;
    logic isCornerD, isCornerE, isCornerS;
    logic [ADDR_W:0] runLenD, runLenE, runLenS;

    int errCount = 0;
    int chkCount = 0;

    assign startD = start & ~sel;
    assign stepD  = step  & ~sel;
    assign hitD   = hit   & ~sel;
    assign abortD = abort & ~sel;
    assign startE = start &  sel;
    assign stepE  = step  &  sel;
    assign hitE   = hit   &  sel;
    assign abortE = abort &  sel;

    assign posAddrS  = sel ? posAddrE  : posAddrD;
    assign busyS     = sel ? busyE     : busyD;
    assign doneS     = sel ? doneE     : doneD;
    assign isCornerS = sel ? isCornerE : isCornerD;
    assign runLenS   = sel ? runLenE   : runLenD;

    arc_match_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ARC_LEN(ARC_LEN), .EARLY_EXIT(1'b0)) dut (
        .clock(clock), .nReset(nReset), .start(startD), .step(stepD), .hit(hitD), .abort(abortD),
        .posAddr(posAddrD), .busy(busyD), .done(doneD), .isCorner(isCornerD), .runLen(runLenD)
    );

    arc_match_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ARC_LEN(ARC_LEN), .EARLY_EXIT(1'b1)) dutEarly (
        .clock(clock), .nReset(nReset), .start(startE), .step(stepE), .hit(hitE), .abort(abortE),
        .posAddr(posAddrE), .busy(busyE), .done(doneE), .isCorner(isCornerE), .runLen(runLenE)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int observed, input int expected);
        chkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Longest circular run of ones; early exit stops at the first linear run of ARC_LEN
    function automatic void modelResult(input logic [DEPTH-1:0] pat, input bit ee,
                                        output int len, output bit corner, output int exitPos);
        int run;
        bit found;
        len = 0;
        exitPos = DEPTH - 1;
        found = 1'b0;
        if (ee) begin
            run = 0;
            for (int p = 0; p < DEPTH; p++) begin
                run = pat[p] ? run + 1 : 0;
                if (!found && run >= ARC_LEN) begin
                    found = 1'b1;
                    exitPos = p;
                end
            end
        end
        if (found) begin
            len = ARC_LEN;
        end else if (&pat) begin
            len = DEPTH;
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                int k;
                k = 0;
                while (k < DEPTH && pat[(s + k) % DEPTH]) k++;
                if (k > len) len = k;
            end
        end
        corner = (len >= ARC_LEN);
    endfunction

    task automatic runScan(input logic [DEPTH-1:0] pat, input bit randStep, input bit ee, input bit pokeStart);
        int pos, edges, expLen, exitPos;
        bit fin, expCorner;
        modelResult(pat, ee, expLen, expCorner, exitPos);
        sel = ee;
        start = 1'b1; step = 1'b0; hit = 1'b0; abort = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        check("acceptBusy", int'(busyS), 1);
        check("acceptPos", int'(posAddrS), 0);
        check("acceptLen", int'(runLenS), 0);
        check("acceptCorner", int'(isCornerS), 0);
        pos = 0; edges = 0; fin = 1'b0;
        while (!fin && edges < 200) begin
            step  = randStep ? 1'($urandom_range(0, 1)) : 1'b1;
            hit   = pat[pos];
            start = pokeStart ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clock); #1;
            edges++;
            if (step) begin
                if (pos == exitPos) fin = 1'b1;
                else pos++;
            end
            if (!fin) begin
                check("scanPos", int'(posAddrS), pos);
                check("scanDone", int'(doneS), 0);
                check("scanBusy", int'(busyS), 1);
            end
        end
        if (!fin) check("scanTimeout", 0, 1);
        check("donePulse", int'(doneS), 1);
        check("doneBusy", int'(busyS), 1);
        check("runLen", int'(runLenS), expLen);
        check("isCorner", int'(isCornerS), int'(expCorner));
        if (!randStep) check("latency", edges, exitPos + 1);
        step = 1'b0; hit = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("doneOnce", int'(doneS), 0);
        check("idleBusy", int'(busyS), 0);
        check("heldLen", int'(runLenS), expLen);
        check("heldCorner", int'(isCornerS), int'(expCorner));
    endtask

    task automatic runAbort();
        int pos, edges;
        sel = 1'b0;
        start = 1'b1; step = 1'b0; hit = 1'b0; abort = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        pos = 0; edges = 0;
        while (pos < 7 && edges < 100) begin
            step = (edges % 2 == 0);
            hit  = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
            edges++;
            if (step) pos++;
            check("abortScanPos", int'(posAddrS), pos);
        end
        step = 1'b1; abort = 1'b1; hit = 1'b1;
        @(posedge clock); #1;
        step = 1'b0; abort = 1'b0; hit = 1'b0;
        check("abortBusy", int'(busyS), 0);
        check("abortDone", int'(doneS), 0);
        check("abortPos", int'(posAddrS), 0);
        check("abortLen", int'(runLenS), 0);
        check("abortCorner", int'(isCornerS), 0);
        @(posedge clock); #1;
        check("abortNoDone", int'(doneS), 0);
    endtask

    task automatic runReset();
        int edges;
        // Reset while a corner result is held
        runScan({DEPTH{1'b1}}, 1'b0, 1'b0, 1'b0);
        nReset = 1'b0; #2;
        check("rstHeldCorner", int'(isCornerS), 0);
        check("rstHeldLen", int'(runLenS), 0);
        @(posedge clock); #1;
        nReset = 1'b1;
        // Reset mid-scan at posAddr 5
        sel = 1'b0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; step = 1'b1; hit = 1'b1;
        edges = 0;
        while (posAddrS != ADDR_W'(5) && edges < 50) begin
            @(posedge clock); #1;
            edges++;
        end
        check("rstReachPos5", int'(posAddrS), 5);
        nReset = 1'b0; #2;
        check("rstPos", int'(posAddrS), 0);
        check("rstBusy", int'(busyS), 0);
        check("rstDone", int'(doneS), 0);
        check("rstCorner", int'(isCornerS), 0);
        check("rstLen", int'(runLenS), 0);
        step = 1'b0; hit = 1'b0;
        @(posedge clock); #1;
        nReset = 1'b1;
        @(posedge clock); #1;
        runScan(16'h01FF, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        nReset = 1'b0;
        start = 1'b0; step = 1'b0; hit = 1'b0; abort = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("resetPos", int'(posAddrD), 0);
        check("resetBusy", int'(busyD), 0);
        check("resetDone", int'(doneD), 0);
        check("resetCorner", int'(isCornerD), 0);
        check("resetLen", int'(runLenD), 0);
        check("resetBusyE", int'(busyE), 0);
        nReset = 1'b1;
        @(posedge clock); #1;

        runScan(16'h01FF, 1'b0, 1'b0, 1'b0);
        runScan(16'hF01F, 1'b0, 1'b0, 1'b0);
        runScan(16'hE01F, 1'b0, 1'b0, 1'b0);
        runScan(16'hFFFF, 1'b0, 1'b0, 1'b0);
        runScan(16'h0000, 1'b0, 1'b0, 1'b0);
        runScan(16'h8001, 1'b1, 1'b0, 1'b1);
        runAbort();
        runScan(16'h01FF, 1'b0, 1'b1, 1'b1);
        runScan(16'hFFFF, 1'b0, 1'b1, 1'b0);
        runScan(16'hF01F, 1'b0, 1'b1, 1'b0);
        runScan(16'h7F80, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 24; i++) begin
            logic [DEPTH-1:0] pat;
            pat = DEPTH'($urandom);
            if (i % 3 == 0) pat = pat | DEPTH'($urandom);
            runScan(pat, 1'($urandom_range(0, 1)), 1'(i % 2), 1'($urandom_range(0, 1)));
        end
        runReset();

        $display("Result: errors=%0d of %0d checks", errCount, chkCount);
        $finish;
    end

endmodule
